// File: rtl/gamepad_serial_reader.sv
// Serial gamepad poller: drives a shared latch/clock to 1..NUM_PADS
// NES/SNES-style shift-register pads, collects one data line per pad and
// publishes a registered, active-high button vector with presence flags.
module gamepad_serial_reader #(
  parameter int unsigned NUM_PADS      = 2,
  parameter int unsigned NUM_BUTTONS   = 12,
  parameter int unsigned CLK_DIV       = 150,
  parameter int unsigned POLL_INTERVAL = 416666
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            poll_req,
  input  logic [NUM_PADS-1:0]             pad_data,
  output logic                            pad_latch,
  output logic                            pad_clk,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] buttons,
  output logic [NUM_PADS-1:0]             pad_present,
  output logic                            frame_valid,
  output logic                            busy
);

  localparam int unsigned PW  = $clog2(POLL_INTERVAL);
  localparam int unsigned PHW = $clog2(2 * CLK_DIV);
  localparam int unsigned BW  = $clog2(NUM_BUTTONS + 1);
  localparam int unsigned SW  = NUM_PADS * NUM_BUTTONS;

  localparam logic [PW-1:0]  POLL_LAST  = PW'(POLL_INTERVAL - 1);
  localparam logic [PHW-1:0] HALF_LAST  = PHW'(CLK_DIV - 1);
  localparam logic [PHW-1:0] PHASE_LAST = PHW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0]  BIT_LAST   = BW'(NUM_BUTTONS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [PW-1:0]       poll_q, poll_d;
  logic [PHW-1:0]      phase_q, phase_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [SW-1:0]       samples_q, samples_d, shifted;
  logic                latch_q, latch_d;
  logic                pclk_q, pclk_d;
  logic [SW-1:0]       buttons_q, buttons_d;
  logic [NUM_PADS-1:0] present_q, present_d;
  logic                fv_q, fv_d;
  logic                busy_q, busy_d;

  // Per-pad shift toward bit 0: after NUM_BUTTONS samples the first bit
  // shifted out of the pad lands at index 0.
  always_comb begin
    shifted = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (i == NUM_BUTTONS - 1) shifted[p*NUM_BUTTONS+i] = pad_data[p];
        else                      shifted[p*NUM_BUTTONS+i] = samples_q[p*NUM_BUTTONS+i+1];
      end
    end
  end

  // Frame sequencer: poll timer, latch pulse, bit clocking and publish.
  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path through
    // the case statement leaves one unassigned (which would infer a latch).
    state_d   = state_q;
    poll_d    = poll_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    samples_d = samples_q;
    latch_d   = latch_q;
    pclk_d    = pclk_q;
    buttons_d = buttons_q;
    present_d = present_q;
    fv_d      = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (!enable) begin
          poll_d = '0;
        end else if (poll_req || poll_q == POLL_LAST) begin
          poll_d  = '0;
          phase_d = '0;
          latch_d = 1'b1;
          pclk_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_LATCH;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end

      ST_LATCH: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          bit_d   = '0;
          latch_d = 1'b0;
          pclk_d  = 1'b0;
          state_d = ST_SHIFT;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        // Sample on the last edge of the low half, as pad_clk rises.
        if (phase_q == HALF_LAST) begin
          samples_d = shifted;
          pclk_d    = 1'b1;
          phase_d   = phase_q + 1'b1;
        end else if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_DONE;
          end else begin
            bit_d  = bit_q + 1'b1;
            pclk_d = 1'b0;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_DONE: begin
        // A floating (pulled-down) line reads all zeros: treat as no pad.
        for (int p = 0; p < NUM_PADS; p++) begin
          if (samples_q[p*NUM_BUTTONS +: NUM_BUTTONS] == '0) begin
            buttons_d[p*NUM_BUTTONS +: NUM_BUTTONS] = '0;
            present_d[p] = 1'b0;
          end else begin
            buttons_d[p*NUM_BUTTONS +: NUM_BUTTONS] = ~samples_q[p*NUM_BUTTONS +: NUM_BUTTONS];
            present_d[p] = 1'b1;
          end
        end
        fv_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset forces pad_clk high, latch low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      poll_q    <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      samples_q <= '0;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b1;
      buttons_q <= '0;
      present_q <= '0;
      fv_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before this edge, independent of statement order.
      state_q   <= state_d;
      poll_q    <= poll_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      samples_q <= samples_d;
      latch_q   <= latch_d;
      pclk_q    <= pclk_d;
      buttons_q <= buttons_d;
      present_q <= present_d;
      fv_q      <= fv_d;
      busy_q    <= busy_d;
    end
  end

  assign pad_latch   = latch_q;
  assign pad_clk     = pclk_q;
  assign buttons     = buttons_q;
  assign pad_present = present_q;
  assign frame_valid = fv_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_gamepad_serial_reader.sv
// Directed bench for gamepad_serial_reader with two behavioural pads.
module tb_gamepad_serial_reader;

  localparam int NP = 2;
  localparam int NB = 4;
  localparam int CD = 2;
  localparam int PI = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          poll_req = 1'b0;
  logic [NP-1:0] pad_data;
  logic          pad_latch, pad_clk, frame_valid, busy;
  logic [7:0]    buttons;
  logic [1:0]    pad_present;

  int n_checks = 0;
  int n_fail = 0;

  // Pad model: bit index reloads on latch, advances on each pad_clk rise.
  logic [3:0] pat0 = 4'b0000;
  logic [3:0] pat1 = 4'b0000;
  int idx = 0;

  // Activity monitors sampled on the falling clk edge.
  int   cyc = 0;
  int   latch_cyc = 0, clk_low_cyc = 0, clk_falls = 0, fv_cnt = 0;
  logic prev_clk = 1'b1;
  int   c0, s_latch, s_low, s_falls, s_fv, lat;

  gamepad_serial_reader #(
    .NUM_PADS(NP), .NUM_BUTTONS(NB), .CLK_DIV(CD), .POLL_INTERVAL(PI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .poll_req(poll_req),
    .pad_data(pad_data), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .buttons(buttons), .pad_present(pad_present),
    .frame_valid(frame_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pad_latch) latch_cyc <= latch_cyc + 1;
    if (!pad_clk) clk_low_cyc <= clk_low_cyc + 1;
    if (prev_clk && !pad_clk) clk_falls <= clk_falls + 1;
    prev_clk <= pad_clk;
    if (frame_valid) fv_cnt <= fv_cnt + 1;
  end

  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) idx <= 0;
    else           idx <= idx + 1;
  end

  assign pad_data = (idx < NB) ? {pat1[idx[1:0]], pat0[idx[1:0]]} : 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for frame_valid; lat = cycles since start edge, -1 on timeout.
  task automatic wait_fv(input int start, output int l);
    l = -1;
    for (int k = 0; k < 200; k++) begin
      if (frame_valid) begin
        l = cyc - start;
        break;
      end
      @(negedge clk);
    end
    if (l < 0) check("fv_timeout", 32'd0, 32'd1);
  endtask

  // Pulse poll_req for one cycle with enable high, snapshot monitors.
  task automatic start_poll();
    @(negedge clk);
    enable   = 1'b1;
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    c0      = cyc;
    s_latch = latch_cyc;
    s_low   = clk_low_cyc;
    s_falls = clk_falls;
  endtask

  initial begin
    int t1, changes;

    // 1: reset and idle with enable low
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t1_latch", pad_latch, 0);
    check("t1_clk", pad_clk, 1);
    check("t1_buttons", buttons, 0);
    check("t1_present", pad_present, 0);
    check("t1_busy", busy, 0);
    check("t1_fv_count", fv_cnt, 0);

    // 2: manual poll, both pads present
    pat0 = 4'b0110;
    pat1 = 4'b1111;
    start_poll();
    check("t2_busy", busy, 1);
    wait_fv(c0, lat);
    check("t2_latency", lat, 21);
    check("t2_latch_cycles", latch_cyc - s_latch, 4);
    check("t2_clk_pulses", clk_falls - s_falls, 4);
    check("t2_clk_low_cycles", clk_low_cyc - s_low, 8);
    check("t2_buttons", buttons, 8'b0000_1001);
    check("t2_present", pad_present, 2'b11);
    check("t2_busy_at_fv", busy, 0);
    enable = 1'b0;
    @(negedge clk);
    check("t2_fv_one_cycle", frame_valid, 0);

    // 3: pad1 absent, pad0 reports bit 2 released only
    pat0 = 4'b0100;
    pat1 = 4'b0000;
    start_poll();
    wait_fv(c0, lat);
    enable = 1'b0;
    check("t3_latency", lat, 21);
    check("t3_present", pad_present, 2'b01);
    check("t3_buttons", buttons, 8'b0000_1011);

    // 4: automatic polling at POLL_INTERVAL
    pat0 = 4'b1010;
    pat1 = 4'b0011;
    @(negedge clk);
    enable = 1'b1;
    wait_fv(cyc, lat);
    check("t4_first_lat", lat, PI + 21);
    check("t4_buttons", buttons, 8'b1100_0101);
    check("t4_present", pad_present, 2'b11);
    for (int r = 0; r < 2; r++) begin
      t1 = cyc;
      changes = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (buttons !== 8'b1100_0101) changes++;
        if (frame_valid) break;
      end
      check("t4_spacing", cyc - t1, 85);
      check("t4_stable", changes, 0);
    end
    enable = 1'b0;
    repeat (5) @(negedge clk);

    // 5: poll_req during SHIFT and enable dropped mid-frame
    pat0 = 4'b0001;
    pat1 = 4'b1000;
    s_fv = fv_cnt;
    start_poll();
    for (int k = 0; k < 50 && pad_clk; k++) @(negedge clk);
    check("t5_in_shift", pad_clk, 0);
    poll_req = 1'b1;
    enable   = 1'b0;
    @(negedge clk);
    poll_req = 1'b0;
    wait_fv(c0, lat);
    check("t5_latency", lat, 21);
    check("t5_buttons", buttons, 8'b0111_1110);
    check("t5_present", pad_present, 2'b11);
    repeat (150) @(negedge clk);
    check("t5_frame_count", fv_cnt - s_fv, 1);
    check("t5_idle_busy", busy, 0);

    // 6: asynchronous reset during bit 2, then a clean frame
    pat0 = 4'b1100;
    pat1 = 4'b0101;
    start_poll();
    for (int k = 0; k < 50 && (clk_falls - s_falls) < 3; k++) @(negedge clk);
    check("t6_pre_clk", pad_clk, 0);
    check("t6_pre_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_clk", pad_clk, 1);
    check("t6_rst_latch", pad_latch, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_buttons", buttons, 0);
    check("t6_rst_present", pad_present, 0);
    check("t6_rst_fv", frame_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_poll();
    wait_fv(c0, lat);
    check("t6_latency", lat, 21);
    check("t6_buttons", buttons, 8'b1010_0011);
    check("t6_present", pad_present, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gamepad_serial_reader.md
Name: gamepad_serial_reader

Overview:
- Parametrised serial gamepad poller for the TinyTapeStation top level. Polls 1..N NES/SNES-style shift-register controllers wired to PMOD pins through a shared latch and clock and one data line per pad.
- Presents a registered, active-high button vector per pad to the game logic, with pad-present flags and a one-cycle frame strobe.
- Replaces the fixed single-pad, hard-coded input path with configurable pad count, button count, bit timing and poll rate.

Parameters:
- NUM_PADS, 2, number of controllers polled in parallel (1..4).
- NUM_BUTTONS, 12, bits shifted per pad per frame (1..16); 8 = NES, 12 = SNES.
- CLK_DIV, 150, length of each pad_clk half-period in clk cycles (>=1); 150 gives 6 us at 25 MHz.
- POLL_INTERVAL, 416666, clk cycles between automatic polls (>=2); 416666 is about 60 Hz at 25 MHz.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  allows automatic polling; sampled only in IDLE.
- poll_req  input  1  immediate-poll request; honoured only in IDLE with enable=1.
- pad_data  input  NUM_PADS  serial data from each pad; active-low (0 = pressed); PMOD pull-downs.
- pad_latch  output  1  parallel-load strobe to all pads.
- pad_clk  output  1  shift clock to all pads; idles high.
- buttons  output  NUM_PADS*NUM_BUTTONS  active-high pressed flags; pad p bit i at index p*NUM_BUTTONS+i; bit 0 is the first bit shifted out.
- pad_present  output  NUM_PADS  1 = pad detected in the last frame.
- frame_valid  output  1  one-cycle strobe when buttons/pad_present update.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (async assert, sync release): state IDLE, pad_latch=0, pad_clk=1, buttons=0, pad_present=0, frame_valid=0, busy=0. Poll counter, phase counter and bit counter all 0.
- FSM states: IDLE -> LATCH -> SHIFT -> DONE -> IDLE.
- IDLE:
  - Poll counter increments each cycle while enable=1; held at 0 while enable=0.
  - Start condition: counter == POLL_INTERVAL-1, or poll_req=1 (with enable=1).
  - On start: go to LATCH and clear the counter.
  - Start cycle = request edge; pad_latch and busy rise on the next cycle.
- LATCH: pad_latch=1 and pad_clk=1 for exactly 2*CLK_DIV cycles, then SHIFT with bit index 0.
- SHIFT, per bit i = 0..NUM_BUTTONS-1:
  - Low phase: pad_clk=0 for CLK_DIV cycles. pad_data is sampled into the shift register for all pads on the final clk edge of the low phase.
  - High phase: pad_clk=1 for CLK_DIV cycles.
  - After the high phase of bit NUM_BUTTONS-1, go to DONE.
- DONE (1 cycle):
  - buttons = inverted samples.
  - Pad p is absent if all its NUM_BUTTONS samples are 0 (pulled-down floating line). An absent pad gets pad_present[p]=0 and its button bits forced to 0; otherwise pad_present[p]=1.
  - frame_valid=1 in the same cycle the new buttons value first appears; busy=0 in that cycle; next state IDLE.
- Frame latency: frame_valid asserts 1 + 2*CLK_DIV*(1+NUM_BUTTONS) cycles after the start edge.
- buttons and pad_present hold their values between frames; they never show partial frames.
- poll_req while busy: ignored, not queued.
- enable=0 mid-frame: the frame completes normally; no new frame starts.
- poll_req and poll-timer expiry in the same cycle: a single frame starts.
- Counter widths are sized from the parameters via clog2; there is no wrap within legal parameter ranges.
- Reset mid-frame: immediate return to reset values; pad_clk high and pad_latch low asynchronously.

Test Plan (NUM_PADS=2, NUM_BUTTONS=4, CLK_DIV=2, POLL_INTERVAL=64):
1. Reset, then idle 10 cycles with enable=0 -> pad_latch=0, pad_clk=1, buttons=0, pad_present=00, busy=0, frame_valid never high.
2. enable=1, poll_req pulse; pad0 serves 0,1,1,0 and pad1 serves 1,1,1,1 -> pad_latch high 4 cycles; 4 pad_clk low pulses of 2 cycles each; frame_valid exactly 21 cycles after the request edge; buttons=8'b0000_1001; pad_present=2'b11.
3. Pad1 data held 0 for all bits, pad0 all 0 except bit 2=1 -> pad_present=2'b01; buttons[7:4]=0; buttons[3:0]=4'b1011.
4. enable=1 without poll_req -> consecutive frame_valid pulses spaced 64+20+1 cycles apart; buttons stable between pulses.
5. poll_req asserted again during SHIFT, and enable dropped mid-frame -> no extra frame; current frame completes with the correct data; then no further polls.
6. rst_n low during SHIFT bit 2 -> all outputs return to reset values immediately; after release, a poll_req yields a full, correct frame.
